// File: rtl/cpu_controller_pkg.sv
// cpu_controller_pkg: shared opcodes, phase encodings and ALU-op test for the accumulator CPU
//   OPCODE_*  : 3-bit ISA opcodes, matching the alu block
//   phase_t   : 8-phase instruction cycle encoding
//   is_aluop  : 1 for opcodes that read memory and load the accumulator
package cpu_controller_pkg;

    localparam logic [2:0] OPCODE_HLT = 3'd0;
    localparam logic [2:0] OPCODE_SKZ = 3'd1;
    localparam logic [2:0] OPCODE_ADD = 3'd2;
    localparam logic [2:0] OPCODE_AND = 3'd3;
    localparam logic [2:0] OPCODE_XOR = 3'd4;
    localparam logic [2:0] OPCODE_LDA = 3'd5;
    localparam logic [2:0] OPCODE_STO = 3'd6;
    localparam logic [2:0] OPCODE_JMP = 3'd7;

    typedef enum logic [2:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_t;

    function automatic logic is_aluop(input logic [2:0] op);
        return op == OPCODE_ADD || op == OPCODE_AND || op == OPCODE_XOR || op == OPCODE_LDA;
    endfunction

endpackage

// File: rtl/cpu_controller_decode.sv
// ctrl_decode: combinational strobe decode from phase, opcode, zero and halted flag
//   in : phase, opcode, zero, halted
//   out: sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt
module ctrl_decode
    import cpu_controller_pkg::*;
(
    input  phase_t     phase,
    input  logic [2:0] opcode,
    input  logic       zero,
    input  logic       halted,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       ld_pc,
    output logic       ld_ac,
    output logic       wr,
    output logic       data_e,
    output logic       halt
);
    logic aluop;
    assign aluop = is_aluop(opcode);

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        // once halted every strobe except halt stays low
        if (!halted) begin
            case (phase)
                PH_INST_ADDR:  sel = 1'b1;
                PH_INST_FETCH: begin sel = 1'b1; rd = 1'b1; end
                PH_INST_LOAD,
                PH_IDLE:       begin sel = 1'b1; rd = 1'b1; ld_ir = 1'b1; end
                PH_OP_ADDR:    inc_pc = 1'b1;
                PH_OP_FETCH:   rd = aluop;
                PH_ALU_OP: begin
                    rd     = aluop;
                    inc_pc = opcode == OPCODE_SKZ && zero;
                    ld_pc  = opcode == OPCODE_JMP;
                    data_e = opcode == OPCODE_STO;
                end
                PH_STORE: begin
                    rd     = aluop;
                    ld_ac  = aluop;
                    inc_pc = opcode == OPCODE_JMP;
                    ld_pc  = opcode == OPCODE_JMP;
                    wr     = opcode == OPCODE_STO;
                    data_e = opcode == OPCODE_STO;
                end
                default: ;
            endcase
        end
        // halt rises combinationally in the HLT OP_ADDR cycle, before the flag registers
        halt = halted || (phase == PH_OP_ADDR && opcode == OPCODE_HLT);
    end
endmodule

// File: rtl/cpu_controller.sv
// cpu_controller: 8-phase instruction sequencer for the 8-bit accumulator CPU
//   in : clk, rst (async, active-high), opcode[2:0], zero
//   out: sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt
module cpu_controller
    import cpu_controller_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       ld_pc,
    output logic       ld_ac,
    output logic       wr,
    output logic       data_e,
    output logic       halt
);
    phase_t phase, phase_nxt;
    logic   halted, halted_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase  <= PH_INST_ADDR;
            halted <= 1'b0;
        end else begin
            phase  <= phase_nxt;
            halted <= halted_nxt;
        end
    end

    // the phase freezes at OP_ADDR from the same edge that sets the halted flag
    always_comb begin
        halted_nxt = halted || (phase == PH_OP_ADDR && opcode == OPCODE_HLT);
        phase_nxt  = halted_nxt ? phase : phase_t'(phase + 3'd1);
    end

    ctrl_decode u_decode (
        .phase  (phase),
        .opcode (opcode),
        .zero   (zero),
        .halted (halted),
        .sel    (sel),
        .rd     (rd),
        .ld_ir  (ld_ir),
        .inc_pc (inc_pc),
        .ld_pc  (ld_pc),
        .ld_ac  (ld_ac),
        .wr     (wr),
        .data_e (data_e),
        .halt   (halt)
    );
endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: table-driven, directed and randomized checks of cpu_controller
module tb_cpu_controller;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] opcode = 3'd0;
    logic       zero = 1'b0;
    logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
    logic [8:0] out;

    int errors = 0;
    int checks = 0;

    // reference state: phase as a plain count 0..7 and a halted bit
    int m_ph = 0;
    bit m_hl = 1'b0;

    always #5 clk = ~clk;

    assign out = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};

    cpu_controller dut (
        .clk    (clk),
        .rst    (rst),
        .opcode (opcode),
        .zero   (zero),
        .sel    (sel),
        .rd     (rd),
        .ld_ir  (ld_ir),
        .inc_pc (inc_pc),
        .ld_pc  (ld_pc),
        .ld_ac  (ld_ac),
        .wr     (wr),
        .data_e (data_e),
        .halt   (halt)
    );

    // expected strobes {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e,halt} from the phase rules
    function automatic logic [8:0] model_out(int ph, int op, bit z, bit hl);
        bit alu = (op >= 2 && op <= 5);
        bit e_sel, e_rd, e_ir, e_inc, e_ldpc, e_ldac, e_wr, e_de, e_halt;
        if (hl) return 9'b000000001;
        e_sel  = ph < 4;
        e_rd   = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
        e_ir   = ph == 2 || ph == 3;
        e_inc  = ph == 4 || (ph == 6 && op == 1 && z) || (ph == 7 && op == 7);
        e_ldpc = ph >= 6 && op == 7;
        e_ldac = ph == 7 && alu;
        e_wr   = ph == 7 && op == 6;
        e_de   = ph >= 6 && op == 6;
        e_halt = ph == 4 && op == 0;
        return {e_sel, e_rd, e_ir, e_inc, e_ldpc, e_ldac, e_wr, e_de, e_halt};
    endfunction

    task automatic check(input string name, input logic [8:0] exp);
        checks++;
        if (out !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, out, exp, $time);
        end
    endtask

    task automatic model_advance();
        if (m_ph == 4 && opcode == 3'd0) m_hl = 1'b1;
        if (!m_hl) m_ph = (m_ph + 1) % 8;
    endtask

    // advance one clock; called at a negedge, returns at the next negedge
    task automatic step();
        model_advance();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_ph = 0;
        m_hl = 1'b0;
    endtask

    typedef struct {
        logic [2:0] op;
        logic       z;
        logic [8:0] e4, e5, e6, e7;
    } vec_t;

    vec_t vecs[6];
    logic [8:0] pre[4];
    logic [8:0] exp;

    initial begin
        pre[0] = 9'b100000000;
        pre[1] = 9'b110000000;
        pre[2] = 9'b111000000;
        pre[3] = 9'b111000000;
        vecs[0] = '{3'd2, 1'b0, 9'b000100000, 9'b010000000, 9'b010000000, 9'b010001000};
        vecs[1] = '{3'd5, 1'b1, 9'b000100000, 9'b010000000, 9'b010000000, 9'b010001000};
        vecs[2] = '{3'd1, 1'b1, 9'b000100000, 9'b000000000, 9'b000100000, 9'b000000000};
        vecs[3] = '{3'd1, 1'b0, 9'b000100000, 9'b000000000, 9'b000000000, 9'b000000000};
        vecs[4] = '{3'd6, 1'b0, 9'b000100000, 9'b000000000, 9'b000000010, 9'b000000110};
        vecs[5] = '{3'd7, 1'b1, 9'b000100000, 9'b000000000, 9'b000010000, 9'b000110000};

        #1 check("reset_during", 9'b100000000);
        do_reset();
        check("reset_after", 9'b100000000);

        // one full instruction per table record
        for (int v = 0; v < 6; v++) begin
            do_reset();
            opcode = vecs[v].op;
            zero = vecs[v].z;
            for (int p = 0; p < 8; p++) begin
                exp = p < 4 ? pre[p] : p == 4 ? vecs[v].e4 : p == 5 ? vecs[v].e5 : p == 6 ? vecs[v].e6 : vecs[v].e7;
                #1 check($sformatf("vec%0d_op%0d_ph%0d", v, vecs[v].op, p), exp);
                step();
            end
            check($sformatf("vec%0d_wrap", v), pre[0]);
        end

        // async reset at phase 5 aborts the instruction, then 8 clean phases
        do_reset();
        opcode = 3'd2;
        zero = 1'b0;
        for (int p = 0; p < 5; p++) step();
        #1 check("pre_abort_ph5", 9'b010000000);
        #1 rst = 1'b1;
        #1 check("async_reset", 9'b100000000);
        @(negedge clk);
        rst = 1'b0;
        m_ph = 0;
        m_hl = 1'b0;
        for (int p = 0; p < 8; p++) begin
            #1 check($sformatf("post_abort_ph%0d", p), model_out(p, 2, 1'b0, 1'b0));
            step();
        end

        // HLT: halt in OP_ADDR, frozen thereafter, cleared only by rst
        do_reset();
        opcode = 3'd0;
        for (int p = 0; p < 4; p++) step();
        #1 check("hlt_op_addr", 9'b000100001);
        step();
        for (int i = 0; i < 22; i++) begin
            opcode = 3'($urandom_range(0, 7));
            zero = 1'($urandom);
            #1 check($sformatf("halted_%0d", i), 9'b000000001);
            step();
        end
        do_reset();
        check("hlt_cleared", 9'b100000000);
        step();
        check("hlt_restart_ph1", 9'b110000000);

        // randomized run against the reference model
        do_reset();
        begin
            int hold = 0;
            for (int i = 0; i < 1500; i++) begin
                opcode = 3'($urandom_range(0, 7));
                if (opcode == 3'd0 && $urandom_range(0, 5) != 0) opcode = 3'd3;
                zero = 1'($urandom);
                #1 check("random", model_out(m_ph, int'(opcode), zero, m_hl));
                if (m_hl) hold++;
                if (hold > 4) begin
                    hold = 0;
                    do_reset();
                end else begin
                    step();
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
